// File: rtl/lock_ctrl_if.sv
// Keypad/actuator bundle for lock_ctrl: keypad and relock inputs, lock status outputs.
// The master side drives keys, the slave side (lock_ctrl) drives status.
interface lock_ctrl_if;
  logic [4:0] key_code;
  logic       key_strobe;
  logic       relock;
  logic       unlocked;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic [3:0] digit_cnt;
  logic [2:0] state_o;

  modport master (
    output key_code, key_strobe, relock,
    input  unlocked, alarm, fail_cnt, digit_cnt, state_o
  );

  modport slave (
    input  key_code, key_strobe, relock,
    output unlocked, alarm, fail_cnt, digit_cnt, state_o
  );
endinterface

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: digit entry, code check, timed unlock and alarm lockout.
// Optional code programming from OPEN is enabled by defining LOCK_PROGRAM_EN.
module lock_ctrl #(
  parameter int                   NDIGITS       = 4,
  parameter logic [4*NDIGITS-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int                   MAX_FAILS     = 3,
  parameter int                   ENTRY_TIMEOUT = 5000,
  parameter int                   OPEN_CYCLES   = 3000,
  parameter int                   ALARM_CYCLES  = 10000
) (
  input  logic        clk,
  input  logic        rst,
  lock_ctrl_if.slave  io_lk
);

  localparam int BW    = 4 * NDIGITS;
  localparam int TMAX0 = (ENTRY_TIMEOUT > OPEN_CYCLES) ? ENTRY_TIMEOUT : OPEN_CYCLES;
  localparam int TMAX  = (TMAX0 > ALARM_CYCLES) ? TMAX0 : ALARM_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [2:0] S_LOCKED = 3'd0;
  localparam logic [2:0] S_ENTRY  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_OPEN   = 3'd3;
  localparam logic [2:0] S_PROG   = 3'd4;
  localparam logic [2:0] S_ALARM  = 3'd5;

  localparam logic [4:0] K_ENTER = 5'd10;
  localparam logic [4:0] K_CLEAR = 5'd11;
`ifdef LOCK_PROGRAM_EN
  localparam logic [4:0] K_SET   = 5'd12;
`endif

  function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] b, input logic [3:0] d);
    shift_in = (b << 4) | BW'(d);
  endfunction

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic          r_strobe_q;
  logic [BW-1:0] r_buf;
  logic [3:0]    r_cnt;
  logic          r_ovf;
  logic [2:0]    r_fail;
  logic [TW-1:0] r_tmr;
  logic [BW-1:0] w_code;

  logic       w_evt, w_digit, w_enter, w_clear, w_expired, w_full, w_match;
  logic [2:0] w_new_fail;

  assign w_evt      = io_lk.key_strobe & ~r_strobe_q;
  assign w_digit    = w_evt & (io_lk.key_code < 5'd10);
  assign w_enter    = w_evt & (io_lk.key_code == K_ENTER);
  assign w_clear    = w_evt & (io_lk.key_code == K_CLEAR);
  assign w_expired  = (r_tmr == {TW{1'b0}});
  assign w_full     = (r_cnt == 4'(NDIGITS));
  assign w_match    = w_full & ~r_ovf & (r_buf == w_code);
  assign w_new_fail = r_fail + 3'd1;

`ifdef LOCK_PROGRAM_EN
  logic w_set;
  logic [BW-1:0] r_code;
  assign w_set  = w_evt & (io_lk.key_code == K_SET);
  assign w_code = r_code;

  // Stored combination, rewritten by a well-formed ENTER in PROG
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code <= DEFAULT_CODE;
    end else if ((r_state == S_PROG) && !w_expired && w_enter && w_full && !r_ovf) begin
      r_code <= r_buf;
    end
  end
`else
  assign w_code = DEFAULT_CODE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; timer expiry outranks any same-cycle key
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOCKED: begin
        if (w_digit) w_next_state = S_ENTRY;
        else         w_next_state = S_LOCKED;
      end
      S_ENTRY: begin
        if (w_expired || w_clear) w_next_state = S_LOCKED;
        else if (w_enter)         w_next_state = S_CHECK;
        else                      w_next_state = S_ENTRY;
      end
      S_CHECK: begin
        if (w_match)                          w_next_state = S_OPEN;
        else if (w_new_fail == 3'(MAX_FAILS)) w_next_state = S_ALARM;
        else                                  w_next_state = S_LOCKED;
      end
      S_OPEN: begin
        if (io_lk.relock || w_expired || w_clear) w_next_state = S_LOCKED;
`ifdef LOCK_PROGRAM_EN
        else if (w_set)                           w_next_state = S_PROG;
`endif
        else                                      w_next_state = S_OPEN;
      end
`ifdef LOCK_PROGRAM_EN
      S_PROG: begin
        if (w_expired || w_clear || w_enter) w_next_state = S_OPEN;
        else                                 w_next_state = S_PROG;
      end
`endif
      S_ALARM: begin
        if (w_expired) w_next_state = S_LOCKED;
        else           w_next_state = S_ALARM;
      end
      default: w_next_state = S_LOCKED;
    endcase
  end

  // Datapath: strobe edge detect, shared timer, entry buffer, fail counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe_q <= 1'b0;
      r_tmr      <= {TW{1'b0}};
      r_buf      <= {BW{1'b0}};
      r_cnt      <= 4'd0;
      r_ovf      <= 1'b0;
      r_fail     <= 3'd0;
    end else begin
      r_strobe_q <= io_lk.key_strobe;

      // The timer serves as idle, hold or alarm counter depending on the state it is loaded for
      if (w_next_state != r_state) begin
        case (w_next_state)
          S_ENTRY, S_PROG: r_tmr <= TW'(ENTRY_TIMEOUT);
          S_OPEN:          r_tmr <= TW'(OPEN_CYCLES - 1);
          S_ALARM:         r_tmr <= TW'(ALARM_CYCLES - 1);
          default:         r_tmr <= {TW{1'b0}};
        endcase
      end else if (w_evt && ((r_state == S_ENTRY) || (r_state == S_PROG))) begin
        r_tmr <= TW'(ENTRY_TIMEOUT);
      end else if (!w_expired) begin
        r_tmr <= r_tmr - TW'(1);
      end

      case (r_state)
        S_LOCKED: begin
          if (w_digit) begin
            r_buf <= shift_in({BW{1'b0}}, io_lk.key_code[3:0]);
            r_cnt <= 4'd1;
            r_ovf <= 1'b0;
          end
        end
        S_ENTRY, S_PROG: begin
          if (w_next_state == S_CHECK) begin
            r_buf <= r_buf;
          end else if (w_next_state != r_state) begin
            r_buf <= {BW{1'b0}};
            r_cnt <= 4'd0;
            r_ovf <= 1'b0;
          end else if (w_digit) begin
            if (!w_full) begin
              r_buf <= shift_in(r_buf, io_lk.key_code[3:0]);
              r_cnt <= r_cnt + 4'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        default: begin
          r_buf <= {BW{1'b0}};
          r_cnt <= 4'd0;
          r_ovf <= 1'b0;
        end
      endcase

      if (r_state == S_CHECK) begin
        r_fail <= w_match ? 3'd0 : w_new_fail;
      end else if ((r_state == S_ALARM) && (w_next_state == S_LOCKED)) begin
        r_fail <= 3'd0;
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    io_lk.unlocked  = (r_state == S_OPEN) || (r_state == S_PROG);
    io_lk.alarm     = (r_state == S_ALARM);
    io_lk.fail_cnt  = r_fail;
    io_lk.digit_cnt = r_cnt;
    io_lk.state_o   = r_state;
  end

endmodule
